// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches, a screen-clear engine and CPU accesses
// share one synchronous RAM port by fixed priority (video > clear > CPU).
module vram_arbiter #(
    parameter int          ADDR_W = 12,
    parameter int          CELLS  = 2400,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic              CLK_25MHZ,
    input  logic              RESET,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic              VID_VALID,
    output logic [7:0]        VID_RDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [7:0]        CPU_WDATA,
    output logic              CPU_ACK,
    output logic              CPU_RVALID,
    output logic [7:0]        CPU_RDATA,
    input  logic              CLR_START,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [7:0]        RAM_WDATA,
    input  logic [7:0]        RAM_RDATA
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    clr_state_t        state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              clr_busy_r;
    logic              clr_done_r;
    logic              vid_valid_r;
    logic              cpu_rvalid_r;
    logic              cpu_ack_r;
    logic              clr_grant_s;
    logic              cpu_grant_s;

    // Grant decode; RESET gates the combinational grants so nothing reaches the RAM during reset.
    always_comb begin
        clr_grant_s = 1'b0;
        cpu_grant_s = 1'b0;
        if (RESET) begin
            clr_grant_s = 1'b0;
            cpu_grant_s = 1'b0;
        end else if (VID_REQ) begin
            clr_grant_s = 1'b0;
            cpu_grant_s = 1'b0;
        end else if (clr_busy_r) begin
            clr_grant_s = 1'b1;
        end else begin
            cpu_grant_s = CPU_REQ & ~cpu_ack_r;
        end
    end

    // RAM port mux for the current grant.
    always_comb begin
        RAM_ADDR  = VID_ADDR;
        RAM_WE    = 1'b0;
        RAM_WDATA = 8'h00;
        if (clr_grant_s) begin
            RAM_ADDR  = clr_addr_r;
            RAM_WE    = 1'b1;
            RAM_WDATA = FILL;
        end else if (cpu_grant_s) begin
            RAM_ADDR  = CPU_ADDR;
            RAM_WE    = CPU_WE;
            RAM_WDATA = CPU_WDATA;
        end else begin
            RAM_ADDR  = VID_ADDR;
            RAM_WE    = 1'b0;
            RAM_WDATA = 8'h00;
        end
    end

    // Clear FSM; the counter holds at the last cell so it can never wrap into unused VRAM.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            state_r    <= IDLE;
            clr_addr_r <= {ADDR_W{1'b0}};
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (CLR_START) begin
                        state_r    <= CLEAR;
                        clr_addr_r <= {ADDR_W{1'b0}};
                        clr_busy_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_grant_s) begin
                        if (clr_addr_r == LAST_ADDR) begin
                            state_r    <= IDLE;
                            clr_busy_r <= 1'b0;
                            clr_done_r <= 1'b1;
                        end else begin
                            clr_addr_r <= clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    clr_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-valid pipeline matching the one-cycle RAM latency, plus the ack history for spacing.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            vid_valid_r  <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            cpu_ack_r    <= 1'b0;
        end else begin
            vid_valid_r  <= VID_REQ;
            cpu_rvalid_r <= cpu_grant_s & ~CPU_WE;
            cpu_ack_r    <= cpu_grant_s;
        end
    end

    assign CPU_ACK    = cpu_grant_s;
    assign VID_VALID  = vid_valid_r;
    assign CPU_RVALID = cpu_rvalid_r;
    assign VID_RDATA  = RAM_RDATA;
    assign CPU_RDATA  = RAM_RDATA;
    assign CLR_BUSY   = clr_busy_r;
    assign CLR_DONE   = clr_done_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous single-port VRAM.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:4095];

    int total;
    int bad;

    vram_arbiter dut (
        .CLK_25MHZ (clk),
        .RESET     (rst),
        .VID_REQ   (vid_req),
        .VID_ADDR  (vid_addr),
        .VID_VALID (vid_valid),
        .VID_RDATA (vid_rdata),
        .CPU_REQ   (cpu_req),
        .CPU_WE    (cpu_we),
        .CPU_ADDR  (cpu_addr),
        .CPU_WDATA (cpu_wdata),
        .CPU_ACK   (cpu_ack),
        .CPU_RVALID(cpu_rvalid),
        .CPU_RDATA (cpu_rdata),
        .CLR_START (clr_start),
        .CLR_BUSY  (clr_busy),
        .CLR_DONE  (clr_done),
        .RAM_ADDR  (ram_addr),
        .RAM_WE    (ram_we),
        .RAM_WDATA (ram_wdata),
        .RAM_RDATA (ram_rdata)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Synchronous RAM: read data reflects the pre-write contents, one cycle after the address.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int early_done;
        int ack_seen;
        int vid_miss;
        int errs;
        logic prev_vid;

        total = 0;
        bad = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h41;
        mem[16'h0960] = 8'hA5;
        rst = 1'b1;
        vid_req = 1'b0; vid_addr = 12'h000;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h001; cpu_wdata = 8'hFF;
        clr_start = 1'b0;

        // Reset state, with a CPU request present that must not be granted
        tick(); tick();
        #1;
        check("rst_ack", 32'(cpu_ack), 32'h0);
        check("rst_we", 32'(ram_we), 32'h0);
        check("rst_vvalid", 32'(vid_valid), 32'h0);
        check("rst_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_busy", 32'(clr_busy), 32'h0);
        check("rst_done", 32'(clr_done), 32'h0);
        cpu_req = 1'b0;
        rst = 1'b0;
        tick();

        // Video read
        vid_req = 1'b1; vid_addr = 12'h010;
        #1;
        check("vid_we", 32'(ram_we), 32'h0);
        check("vid_addr", 32'(ram_addr), 32'h010);
        tick();
        vid_req = 1'b0;
        #1;
        check("vid_valid", 32'(vid_valid), 32'h1);
        check("vid_rdata", 32'(vid_rdata), 32'h41);
        tick();
        check("vid_valid_drop", 32'(vid_valid), 32'h0);

        // CPU write blocked by three video cycles, then read back
        vid_req = 1'b1; vid_addr = 12'h020;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("cpu_blocked_by_vid", 32'(cpu_ack), 32'h0);
            tick();
        end
        vid_req = 1'b0;
        #1;
        check("cpu_wr_ack", 32'(cpu_ack), 32'h1);
        check("cpu_wr_we", 32'(ram_we), 32'h1);
        check("cpu_wr_addr", 32'(ram_addr), 32'h123);
        check("cpu_wr_data", 32'(ram_wdata), 32'h5A);
        tick();
        cpu_we = 1'b0;
        #1;
        check("cpu_no_b2b", 32'(cpu_ack), 32'h0);
        check("cpu_wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
        tick();
        #1;
        check("cpu_rd_ack", 32'(cpu_ack), 32'h1);
        check("cpu_rd_we", 32'(ram_we), 32'h0);
        tick();
        cpu_req = 1'b0;
        #1;
        check("cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("cpu_rdata", 32'(cpu_rdata), 32'h5A);
        tick();

        // Continuous CPU request: grants alternate
        cpu_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("cpu_alternate", 32'(cpu_ack), (c % 2 == 0) ? 32'h1 : 32'h0);
            tick();
        end
        cpu_req = 1'b0;
        tick();

        // Clear with no video traffic; a second start mid-clear is ignored
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cnt = 0; early_done = 0;
        for (int i = 0; i < 3000 && clr_busy; i++) begin
            if (clr_done) early_done++;
            clr_start = (i == 100);
            busy_cnt++;
            tick();
        end
        clr_start = 1'b0;
        check("clr1_finished", 32'(clr_busy), 32'h0);
        check("clr1_busy_cycles", 32'(busy_cnt), 32'd2400);
        check("clr1_no_early_done", 32'(early_done), 32'h0);
        check("clr1_done", 32'(clr_done), 32'h1);
        tick();
        check("clr1_done_pulse", 32'(clr_done), 32'h0);
        errs = 0;
        for (int a = 0; a < 2400; a++) if (mem[a] !== 8'h20) errs++;
        check("clr1_cells", 32'(errs), 32'h0);
        check("clr1_untouched", 32'(mem[16'h0960]), 32'hA5);

        // Clear with video every other cycle and a CPU request held throughout
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h050;
        busy_cnt = 0; ack_seen = 0; vid_miss = 0; prev_vid = 1'b0;
        for (int i = 0; i < 6000 && clr_busy; i++) begin
            vid_req = (i % 2 == 0);
            vid_addr = 12'(i);
            #1;
            if (cpu_ack) ack_seen++;
            if (vid_valid !== prev_vid) vid_miss++;
            prev_vid = vid_req;
            busy_cnt++;
            tick();
        end
        vid_req = 1'b0;
        check("clr2_finished", 32'(clr_busy), 32'h0);
        check("clr2_busy_cycles", 32'(busy_cnt), 32'd4800);
        check("clr2_no_cpu_ack", 32'(ack_seen), 32'h0);
        check("clr2_vid_valid", 32'(vid_miss), 32'h0);
        check("clr2_done", 32'(clr_done), 32'h1);
        #1;
        check("clr2_cpu_granted", 32'(cpu_ack), 32'h1);
        tick();
        cpu_req = 1'b0;
        check("clr2_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("clr2_cpu_rdata", 32'(cpu_rdata), 32'h20);
        tick();

        // Reset in the middle of a clear, then restart from address 0
        for (int a = 0; a < 2400; a++) mem[a] = 8'h00;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        #1;
        check("abort_addr", 32'(ram_addr), 32'd1000);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(clr_busy), 32'h0);
        check("abort_we", 32'(ram_we), 32'h0);
        check("abort_done", 32'(clr_done), 32'h0);
        tick();
        rst = 1'b0;
        check("abort_last_written", 32'(mem[999]), 32'h20);
        check("abort_not_written", 32'(mem[1000]), 32'h00);
        tick();
        check("abort_no_done", 32'(clr_done), 32'h0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        #1;
        check("restart_addr0", 32'(ram_addr), 32'h000);
        check("restart_we", 32'(ram_we), 32'h1);
        tick();
        #1;
        check("restart_addr1", 32'(ram_addr), 32'h001);
        busy_cnt = 1;
        for (int i = 0; i < 3000 && clr_busy; i++) begin
            busy_cnt++;
            tick();
        end
        check("restart_busy_cycles", 32'(busy_cnt), 32'd2400);
        check("restart_done", 32'(clr_done), 32'h1);

        // Start coincident with done re-enters the clear at address 0
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        #1;
        check("redo_busy", 32'(clr_busy), 32'h1);
        check("redo_addr0", 32'(ram_addr), 32'h000);
        check("redo_we", 32'(ram_we), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning VRAM address width.
REQ-002 SHALL have parameter CELLS, default 2400, meaning the number of text cells cleared (80x30).
REQ-003 SHALL have parameter FILL, default 8'h20, meaning the byte written by clear (ASCII space).
REQ-004 SHALL have port CLK_25MHZ  in  1  the single pixel clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port VID_REQ  in  1  video character-fetch request, one cycle per fetch.
REQ-007 SHALL have port VID_ADDR  in  ADDR_W  video fetch address.
REQ-008 SHALL have port VID_VALID  out  1  VID_RDATA is valid this cycle.
REQ-009 SHALL have port VID_RDATA  out  8  video read data.
REQ-010 SHALL have port CPU_REQ  in  1  CPU access request, held until acknowledged.
REQ-011 SHALL have port CPU_WE  in  1  1 = write, 0 = read; qualified by CPU_REQ.
REQ-012 SHALL have port CPU_ADDR  in  ADDR_W  CPU address.
REQ-013 SHALL have port CPU_WDATA  in  8  CPU write data.
REQ-014 SHALL have port CPU_ACK  out  1  one-cycle grant pulse for the CPU access.
REQ-015 SHALL have port CPU_RVALID  out  1  CPU_RDATA is valid this cycle.
REQ-016 SHALL have port CPU_RDATA  out  8  CPU read data.
REQ-017 SHALL have port CLR_START  in  1  one-cycle pulse that starts a screen clear.
REQ-018 SHALL have port CLR_BUSY  out  1  a clear is in progress.
REQ-019 SHALL have port CLR_DONE  out  1  one-cycle pulse when the clear completes.
REQ-020 SHALL have port RAM_ADDR  out  ADDR_W  address to the single-port VRAM.
REQ-021 SHALL have port RAM_WE  out  1  VRAM write enable.
REQ-022 SHALL have port RAM_WDATA  out  8  VRAM write data.
REQ-023 SHALL have port RAM_RDATA  in  8  VRAM synchronous read data, valid one cycle after the address.

Function
REQ-024 SHALL grant the VRAM port each cycle by fixed priority: video, then clear engine, then CPU.
REQ-025 SHALL drive RAM_ADDR, RAM_WE and RAM_WDATA combinationally in the grant cycle.
REQ-026 SHALL, on a video grant, drive RAM_ADDR=VID_ADDR and RAM_WE=0, and assert VID_VALID exactly one cycle later.
REQ-027 SHALL never stall, drop or reorder a video request.
REQ-028 SHALL drive VID_RDATA and CPU_RDATA from RAM_RDATA; each is meaningful only while its VALID flag is high.
REQ-029 SHALL grant the CPU only when VID_REQ=0, CLR_BUSY=0 and CPU_ACK was not asserted in the previous cycle (no back-to-back grants).
REQ-030 SHALL assert CPU_ACK in the CPU grant cycle, driving RAM_ADDR=CPU_ADDR, RAM_WE=CPU_WE and RAM_WDATA=CPU_WDATA.
REQ-031 SHALL, on a CPU read grant, assert CPU_RVALID exactly one cycle later; no RVALID is produced for a CPU write.
REQ-032 SHALL define the CPU handshake as follows: the CPU holds all CPU_* inputs stable until it samples CPU_ACK=1, then deasserts CPU_REQ or presents a new access.
REQ-033 SHALL implement a clear FSM with states IDLE and CLEAR: IDLE->CLEAR on CLR_START=1; CLEAR->IDLE after the write to address CELLS-1.
REQ-034 SHALL, in CLEAR, hold address counter clr_addr, starting at 0, and on each cycle without VID_REQ write FILL to clr_addr and then increment it.
REQ-035 SHALL, in CLEAR cycles with VID_REQ=1, leave clr_addr unchanged.
REQ-036 SHALL keep CLR_BUSY=1 throughout the CLEAR state.
REQ-037 SHALL pulse CLR_DONE in the cycle after the final write, concurrent with CLR_BUSY returning to 0.
REQ-038 SHALL ignore CLR_START while the FSM is in CLEAR (no restart, no counter reset).
REQ-039 SHALL accept a CLR_START coincident with CLR_DONE, entering CLEAR again with clr_addr=0.
REQ-040 SHALL keep a CPU request that arrives while CLR_BUSY=1 pending, not lost, and grant it after CLR_DONE under normal priority.
REQ-041 SHALL not wrap clr_addr: it stops at CELLS-1, and addresses from CELLS to 2^ADDR_W-1 are never written by clear.

Reset
REQ-042 SHALL, while RESET=1, immediately force the FSM to IDLE, clr_addr=0, and CPU_ACK, CPU_RVALID, VID_VALID, CLR_BUSY, CLR_DONE and RAM_WE all 0.
REQ-043 SHALL abort a clear in progress when RESET is asserted, with no CLR_DONE; any pending CPU request is re-arbitrated after reset deasserts.

Verification
REQ-044 SHALL cover: VID_REQ=1, VID_ADDR=0x010, RAM holds 0x41 -> RAM_WE=0, VID_VALID=1 next cycle, VID_RDATA=0x41.
REQ-045 SHALL cover: CPU write 0x5A to 0x123 with VID_REQ=1 for 3 cycles -> CPU_ACK in cycle 4, RAM_WE=1, RAM_ADDR=0x123; a later read returns 0x5A with CPU_RVALID.
REQ-046 SHALL cover: CLR_START with no video traffic -> CLR_BUSY for 2400 cycles, CLR_DONE at cycle 2401, all cells 0x000-0x95F = 0x20, 0x960 untouched.
REQ-047 SHALL cover: CLR_START with VID_REQ every 2nd cycle -> clear takes 4800 cycles, every video read gets VID_VALID, CPU_REQ gets no ACK until CLR_DONE.
REQ-048 SHALL cover: RESET asserted at clr_addr=1000 -> CLR_BUSY=0 immediately, no CLR_DONE; after a new CLR_START the clear restarts at address 0.
REQ-049 SHALL cover: CPU_REQ held continuously with no video traffic -> CPU_ACK at most every 2nd cycle, never back-to-back.
